// File: rtl/regfile_sequencer.sv
// Execute/write-back sequencer for the 16-entry GPR file.
// Four-phase flow per instruction: accept, read operands, execute, write back.
// Optional macro FLAGS_EN adds registered zero/carry flag outputs.
module regfile_sequencer #(
    parameter int DATA_W       = 32,
    parameter bit SIGN_EXT_IMM = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [3:0]        rf_rs1,
    output logic [3:0]        rf_rs2,
    input  logic [DATA_W-1:0] rf_rs1_data,
    input  logic [DATA_W-1:0] rf_rs2_data,
    output logic [3:0]        rf_rd,
    output logic [DATA_W-1:0] rf_write_imm,
    output logic              rf_write_en_imm,
    output logic [DATA_W-1:0] rf_write_reg_data,
    output logic              rf_write_reg,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] result
`ifdef FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LI   = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;

    logic [3:0]        w_op;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_sub;
    logic [DATA_W-1:0] w_addend;
    logic [DATA_W:0]   w_sum;
    logic [4:0]        w_shamt;
    logic              w_shift_oor;
    logic [DATA_W-1:0] w_alu;

    assign w_op      = r_instr[31:28];
    assign w_imm16   = r_instr[15:0];
    assign w_imm_ext = SIGN_EXT_IMM ? DATA_W'($signed(w_imm16)) : DATA_W'(w_imm16);

    // Single shared adder: ADD, ADDI and SUB (as a + ~b + 1)
    assign w_sub    = (w_op == OP_SUB);
    assign w_addend = (w_op == OP_ADDI) ? w_imm_ext : r_b;
    assign w_sum    = {1'b0, r_a} + {1'b0, (w_sub ? ~w_addend : w_addend)} + (DATA_W+1)'(w_sub);

    assign w_shamt     = r_b[4:0];
    assign w_shift_oor = (32'(w_shamt) >= 32'(DATA_W));

    assign rf_rs1            = r_instr[23:20];
    assign rf_rs2            = r_instr[19:16];
    assign rf_rd             = r_instr[27:24];
    assign rf_write_imm      = w_imm_ext;
    assign rf_write_reg_data = r_result;
    assign result            = r_result;

    // ALU result selection for the EXEC phase
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_LI:   w_alu = w_imm_ext;
            OP_MOV:  w_alu = r_a;
            OP_ADD,
            OP_SUB,
            OP_ADDI: w_alu = w_sum[DATA_W-1:0];
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_XOR:  w_alu = r_a ^ r_b;
            OP_SHL:  w_alu = w_shift_oor ? '0 : (r_a << w_shamt);
            OP_SHR:  w_alu = w_shift_oor ? '0 : (r_a >> w_shamt);
            default: w_alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and handshake/strobe decode
    always_comb begin
        w_next          = r_state;
        instr_ready     = 1'b0;
        rf_write_en_imm = 1'b0;
        rf_write_reg    = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_next = S_READ;
            end
            S_READ: w_next = S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB: begin
                done            = 1'b1;
                illegal         = (w_op > OP_ADDI);
                rf_write_en_imm = (w_op == OP_LI);
                rf_write_reg    = (w_op >= OP_MOV) && (w_op <= OP_ADDI);
                w_next          = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Instruction latch, operand capture and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (r_state == S_IDLE && instr_valid) r_instr <= instr;
            if (r_state == S_READ) begin
                r_a <= rf_rs1_data;
                r_b <= rf_rs2_data;
            end
            if (r_state == S_EXEC) r_result <= w_alu;
        end
    end

`ifdef FLAGS_EN
    // Zero/carry flags, updated only by the adder opcodes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (r_state == S_EXEC &&
                     (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_ADDI)) begin
            flag_z <= (w_sum[DATA_W-1:0] == '0);
            flag_c <= w_sum[DATA_W];
        end
    end
`else
    logic w_unused_carry;
    assign w_unused_carry = w_sum[DATA_W];
`endif

endmodule
